// File: rtl/ones_frame_if.sv
// ---------------------------------------------------------------------------
// ones_frame_if
// Purpose : bundles the beat-input and frame-result handshakes of the
//           ones-frame accumulator.
// Signals :
//   in_valid / in_ready   beat handshake (upstream -> accumulator)
//   in_count [3:0]        popcount of one byte, legal 0..8
//   in_last               final beat of the frame, qualified by in_valid
//   out_valid / out_ready result handshake (accumulator -> downstream)
//   out_sum   [SUM_W]     total ones in the frame
//   out_words [WCNT_W]    beats in the frame
//   out_over              out_sum reached the threshold
//   out_err               illegal count, forced close or saturation
// Modports: slave = accumulator view, master = environment view.
// ---------------------------------------------------------------------------
interface ones_frame_if #(
  parameter int SUM_W  = 8,
  parameter int WCNT_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_count;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [WCNT_W-1:0] out_words;
  logic              out_over;
  logic              out_err;

  modport slave (
    input  in_valid, in_count, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_words, out_over, out_err
  );

  modport master (
    output in_valid, in_count, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_words, out_over, out_err
  );
endinterface

// File: rtl/ones_frame_accumulator.sv
// ---------------------------------------------------------------------------
// ones_frame_accumulator
// Purpose : sums per-byte popcounts over a frame of up to MAX_WORDS beats
//           (closed by in_last or by reaching the beat limit) and presents
//           the total, beat count, threshold flag and error flag as a held
//           valid/ready result.
// Ports   :
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ones_frame_if.slave (beat input and result output handshakes)
// ---------------------------------------------------------------------------
module ones_frame_accumulator #(
  parameter int MAX_WORDS = 16,
  parameter int WCNT_W    = 5,
  parameter int SUM_W     = 8,
  parameter int THRESH    = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  ones_frame_if.slave  bus
);

  localparam logic [0:0]  ST_ACC   = 1'b0;
  localparam logic [0:0]  ST_DONE  = 1'b1;
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  logic [0:0]        state_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic [WCNT_W-1:0] words_reg;
  logic              err_reg;

  logic              out_valid_reg;
  logic [SUM_W-1:0]  out_sum_reg;
  logic [WCNT_W-1:0] out_words_reg;
  logic              out_over_reg;
  logic              out_err_reg;

  logic              in_ready_int;
  logic              bad_count;
  logic [3:0]        eff_count;
  logic [SUM_W:0]    sum_wide;
  logic              sat;
  logic [SUM_W-1:0]  sum_next;
  logic [WCNT_W-1:0] words_next;
  logic              limit_hit;
  logic              err_next;
  logic              accept;
  logic              close;
  logic              over_next;

  // Ready is a pure function of state so there is no in_* -> in_ready path.
  assign in_ready_int  = (state_reg == ST_ACC);
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_words = out_words_reg;
  assign bus.out_over  = out_over_reg;
  assign bus.out_err   = out_err_reg;

  always_comb begin
    bad_count  = (bus.in_count > 4'd8);
    eff_count  = bad_count ? 4'd8 : bus.in_count;
    // One extra bit catches the carry out so the sum can clamp instead of wrap.
    sum_wide   = {1'b0, sum_reg} + {{(SUM_W-3){1'b0}}, eff_count};
    sat        = sum_wide[SUM_W];
    sum_next   = sat ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
    words_next = words_reg + WCNT_W'(1);
    limit_hit  = (words_next == WCNT_W'(MAX_WORDS));
    accept     = bus.in_valid && in_ready_int;
    close      = accept && (bus.in_last || limit_hit);
    // A limit close that coincides with in_last is a normal close, not forced.
    err_next   = err_reg | bad_count | sat | (limit_hit & ~bus.in_last);
    over_next  = (32'(sum_next) >= THRESH_U);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_ACC;
      sum_reg       <= '0;
      words_reg     <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_words_reg <= '0;
      out_over_reg  <= 1'b0;
      out_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_ACC: begin
          if (accept) begin
            sum_reg   <= sum_next;
            words_reg <= words_next;
            err_reg   <= err_next;
          end
          if (close) begin
            out_sum_reg   <= sum_next;
            out_words_reg <= words_next;
            out_over_reg  <= over_next;
            out_err_reg   <= err_next;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result fields stay put after the handshake; only valid drops.
          if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            words_reg     <= '0;
            err_reg       <= 1'b0;
            state_reg     <= ST_ACC;
          end
        end
        default: state_reg <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ones_frame_accumulator
// Purpose : directed self-checking bench for ones_frame_accumulator. A
//           frame-level model predicts every output each cycle; directed
//           tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ones_frame_accumulator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ones_frame_if bus ();

  ones_frame_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vecs        = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Frame-level model: beats collected into a running total; a result is
  // owed downstream (busy) from the closing beat until it is taken.
  bit m_busy  = 1'b0;
  int m_sum   = 0;
  int m_words = 0;
  bit m_err   = 1'b0;
  int e_sum   = 0;
  int e_words = 0;
  bit e_over  = 1'b0;
  bit e_err   = 1'b0;
  int c_eff;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_sum = 0; m_words = 0; m_err = 1'b0;
      e_sum = 0; e_words = 0; e_over = 1'b0; e_err = 1'b0;
    end else if (!m_busy) begin
      if (bus.in_valid === 1'b1) begin
        c_eff = int'(bus.in_count);
        if (c_eff > 8) begin
          c_eff = 8;
          m_err = 1'b1;
        end
        m_sum = m_sum + c_eff;
        if (m_sum > 255) begin
          m_sum = 255;
          m_err = 1'b1;
        end
        m_words++;
        if (bus.in_last === 1'b1 || m_words == 16) begin
          if (bus.in_last !== 1'b1) m_err = 1'b1;
          e_sum   = m_sum;
          e_words = m_words;
          e_over  = (m_sum >= 64);
          e_err   = m_err;
          m_busy  = 1'b1;
          m_sum   = 0;
          m_words = 0;
          m_err   = 1'b0;
          $display("frame closed: sum=%0d words=%0d over=%0b err=%0b", e_sum, e_words, e_over, e_err);
        end
      end
    end else if (bus.out_ready === 1'b1) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready",  32'(bus.in_ready),  32'(!m_busy));
      chk("out_valid", 32'(bus.out_valid), 32'(m_busy));
      chk("out_sum",   32'(bus.out_sum),   32'(e_sum));
      chk("out_words", 32'(bus.out_words), 32'(e_words));
      chk("out_over",  32'(bus.out_over),  32'(e_over));
      chk("out_err",   32'(bus.out_err),   32'(e_err));
    end
  end

  // Presents one beat and holds it until the DUT accepts it; waits returns
  // the number of edges at which in_ready was low.
  task automatic send(input logic [3:0] c, input logic last, output int waits);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_count = c;
    bus.in_last  = last;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    waits = n - 1;
    if (!acc) begin
      vecs++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_count = 4'd0;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int s, input int w, input bit ov, input bit er);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.out_sum),   32'(s));
    chk({tag, "_words"}, 32'(bus.out_words), 32'(w));
    chk({tag, "_over"},  32'(bus.out_over),  32'(ov));
    chk({tag, "_err"},   32'(bus.out_err),   32'(er));
  endtask

  int w;
  int k;
  int t6_cnt [9] = '{8, 8, 8, 9, 5, 6, 7, 8, 1};
  bit t6_last[9] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
  int t6_sum [3] = '{24, 8, 27};
  bit t6_err [3] = '{0, 1, 0};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_count  = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check_en = 1'b1;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // reset state
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'd1);
    chk("rst_sum",   32'(bus.out_sum),   32'd0);

    // 1: plain four-beat frame, held until taken
    send(4'd8, 1'b0, w); send(4'd3, 1'b0, w); send(4'd0, 1'b0, w); send(4'd5, 1'b1, w);
    idle();
    chk_result("t1", 16, 4, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_result("t1_hold", 16, 4, 1'b0, 1'b0);
    take_result();
    chk("t1_after_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_after_ready", 32'(bus.in_ready),  32'd1);
    chk("t1_after_sum",   32'(bus.out_sum),   32'd16);

    // 2: forced close at the beat limit, then a fresh frame from zero
    for (int i = 0; i < 16; i++) send(4'd8, 1'b0, w);
    idle();
    chk_result("t2", 128, 16, 1'b1, 1'b1);
    take_result();
    send(4'd1, 1'b0, w); send(4'd2, 1'b1, w);
    idle();
    chk_result("t2_next", 3, 2, 1'b0, 1'b0);
    take_result();

    // 3: single illegal beat
    send(4'd9, 1'b1, w);
    idle();
    chk_result("t3", 8, 1, 1'b0, 1'b1);
    take_result();

    // 4: backpressure with a pending beat
    send(4'd3, 1'b1, w);
    bus.in_valid = 1'b1; bus.in_count = 4'd7; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_stall_ready", 32'(bus.in_ready), 32'd0);
      chk("t4_stall_sum",   32'(bus.out_sum),  32'd3);
    end
    take_result();
    chk("t4_ready_back", 32'(bus.in_ready),  32'd1);
    chk("t4_valid_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    idle();
    chk_result("t4_pending", 7, 1, 1'b0, 1'b0);
    take_result();

    // 5: reset mid-frame discards the partial frame
    send(4'd4, 1'b0, w); send(4'd4, 1'b0, w); send(4'd4, 1'b0, w);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_sum",   32'(bus.out_sum),   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'd2, 1'b0, w); send(4'd2, 1'b1, w);
    idle();
    chk_result("t5", 4, 2, 1'b0, 1'b0);
    take_result();

    // 6: back-to-back frames, out_ready tied high
    bus.out_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      send(4'(t6_cnt[i]), t6_last[i], w);
      if (i > 0 && t6_last[i-1]) chk("t6_bubble", 32'(w), 32'd1);
      else                       chk("t6_no_wait", 32'(w), 32'd0);
      if (t6_last[i]) begin
        chk("t6_sum", 32'(bus.out_sum), 32'(t6_sum[k]));
        chk("t6_err", 32'(bus.out_err), 32'(t6_err[k]));
        k++;
      end
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

endmodule
